// File: rtl/control_sequencer.sv
// Multi-cycle bus-transfer control sequencer (states T0-T3) for a register-file/ALU datapath.
// Optional feature macro: SEQ_RETIRE_CNT_EN adds the 8-bit `retired` instruction counter port.
module control_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [7:0] instr,
   output logic [2:0] regSel,
   output logic       Rin,
   output logic       Rout,
   output logic       Ain,
   output logic       Gin,
   output logic       Gout,
   output logic [1:0] aluOp,
   output logic       extOut,
   output logic       busy,
   output logic       done
`ifdef SEQ_RETIRE_CNT_EN
   ,
   output logic [7:0] retired
`endif
);

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_e;

   localparam logic [1:0] OP_MV  = 2'b00;
   localparam logic [1:0] OP_MVI = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   state_e     state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic [1:0] opcode_s;
   logic [2:0] rx_s, ry_s;

   assign opcode_s = ir_q[7:6];
   assign rx_s     = ir_q[5:3];
   assign ry_s     = ir_q[2:0];

   // State and instruction register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= T0;
         ir_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Next-state and control decode; outputs depend only on state and IR
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      regSel  = 3'd0;
      Rin     = 1'b0;
      Rout    = 1'b0;
      Ain     = 1'b0;
      Gin     = 1'b0;
      Gout    = 1'b0;
      aluOp   = 2'b00;
      extOut  = 1'b0;
      done    = 1'b0;
      busy    = (state_q != T0);
      case (state_q)
         T0: begin
            if (run) begin
               state_d = T1;
               ir_d    = instr;
            end else begin
               state_d = T0;
            end
         end
         T1: begin
            case (opcode_s)
               OP_MV: begin
                  regSel = ry_s;
                  Rout   = 1'b1;
                  Ain    = 1'b1;
               end
               OP_MVI: begin
                  regSel = rx_s;
                  extOut = 1'b1;
                  Rin    = 1'b1;
                  done   = 1'b1;
               end
               default: begin
                  regSel = rx_s;
                  Rout   = 1'b1;
                  Ain    = 1'b1;
               end
            endcase
            if (done) begin
               state_d = T0;
            end else begin
               state_d = T2;
            end
         end
         T2: begin
            // MV only passes A through; ADD/SUB put Ry on the bus as the second operand
            case (opcode_s)
               OP_MV: begin
                  aluOp = 2'b00;
                  Gin   = 1'b1;
               end
               OP_ADD: begin
                  regSel = ry_s;
                  Rout   = 1'b1;
                  aluOp  = 2'b01;
                  Gin    = 1'b1;
               end
               OP_SUB: begin
                  regSel = ry_s;
                  Rout   = 1'b1;
                  aluOp  = 2'b10;
                  Gin    = 1'b1;
               end
               default: begin
                  aluOp = 2'b00;
               end
            endcase
            state_d = T3;
         end
         T3: begin
            regSel  = rx_s;
            Gout    = 1'b1;
            Rin     = 1'b1;
            done    = 1'b1;
            state_d = T0;
         end
         default: begin
            state_d = T0;
         end
      endcase
   end

`ifdef SEQ_RETIRE_CNT_EN
   logic [7:0] retired_q, retired_d;

   // Retired count: bumps on each edge that ends a done cycle, wraps naturally
   always_comb begin
      if (done) begin
         retired_d = retired_q + 8'd1;
      end else begin
         retired_d = retired_q;
      end
   end

   // Retired count register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retired_q <= 8'h00;
      end else begin
         retired_q <= retired_d;
      end
   end

   assign retired = retired_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; retire-counter test only when SEQ_RETIRE_CNT_EN is defined.
module tb_control_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       run = 1'b0;
   logic [7:0] instr = 8'h00;
   logic [2:0] regSel;
   logic       Rin, Rout, Ain, Gin, Gout, extOut, busy, done;
   logic [1:0] aluOp;
`ifdef SEQ_RETIRE_CNT_EN
   logic [7:0] retired;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   // {regSel, Rin, Rout, Ain, Gin, Gout, aluOp, extOut, busy, done}
   logic [12:0] outs;
   assign outs = {regSel, Rin, Rout, Ain, Gin, Gout, aluOp, extOut, busy, done};

   always #5 clk = ~clk;

   control_sequencer dut (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .instr  (instr),
      .regSel (regSel),
      .Rin    (Rin),
      .Rout   (Rout),
      .Ain    (Ain),
      .Gin    (Gin),
      .Gout   (Gout),
      .aluOp  (aluOp),
      .extOut (extOut),
      .busy   (busy),
      .done   (done)
`ifdef SEQ_RETIRE_CNT_EN
      ,
      .retired(retired)
`endif
   );

   task automatic test_reset();
      rst = 1'b0;
      run = 1'b0;
      instr = 8'h00;
      @(negedge clk);
      tests_run++;
      if (outs !== 13'd0) begin
         tests_failed++;
         $display("FAIL reset_hold: got %h expected %h", outs, 13'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (outs !== 13'd0) begin
         tests_failed++;
         $display("FAIL reset_first_cycle: got %h expected %h", outs, 13'd0);
      end
`ifdef SEQ_RETIRE_CNT_EN
      tests_run++;
      if (retired !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_retired: got %h expected %h", retired, 8'h00);
      end
`endif
   endtask

   task automatic test_reset_mid_add();
      instr = 8'h8A;
      run   = 1'b1;
      @(negedge clk);
      run = 1'b0;
      tests_run++;
      if (outs !== {3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL midadd_t1: got %h", outs);
      end
      @(negedge clk);
      tests_run++;
      if (outs !== {3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL midadd_t2: got %h", outs);
      end
      rst = 1'b0;
      #1;
      tests_run++;
      if (outs !== 13'd0) begin
         tests_failed++;
         $display("FAIL midadd_abort: got %h expected %h", outs, 13'd0);
      end
      @(negedge clk);
      tests_run++;
      if (outs !== 13'd0) begin
         tests_failed++;
         $display("FAIL midadd_held: got %h expected %h", outs, 13'd0);
      end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if (outs !== 13'd0) begin
            tests_failed++;
            $display("FAIL midadd_after_release[%0d]: got %h expected %h", i, outs, 13'd0);
         end
      end
`ifdef SEQ_RETIRE_CNT_EN
      tests_run++;
      if (retired !== 8'h00) begin
         tests_failed++;
         $display("FAIL midadd_retired: got %h expected %h", retired, 8'h00);
      end
`endif
   endtask

   task automatic test_mvi();
      instr = 8'h68;
      run   = 1'b1;
      @(negedge clk);
      run = 1'b0;
      tests_run++;
      if (outs !== {3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1}) begin
         tests_failed++;
         $display("FAIL mvi_t1: got %h", outs);
      end
      @(negedge clk);
      tests_run++;
      if (outs !== 13'd0) begin
         tests_failed++;
         $display("FAIL mvi_idle: got %h expected %h", outs, 13'd0);
      end
   endtask

   task automatic test_add();
      logic [12:0] exp [0:3];
      exp[0] = {3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
      exp[1] = {3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
      exp[2] = {3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1};
      exp[3] = 13'd0;
      instr = 8'h8A;
      run   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         run = 1'b0;
         tests_run++;
         if (outs !== exp[i]) begin
            tests_failed++;
            $display("FAIL add_step%0d: got %h expected %h", i + 1, outs, exp[i]);
         end
      end
   endtask

   task automatic test_sub_instr_change();
      logic [12:0] exp [0:3];
      exp[0] = {3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
      exp[1] = {3'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0};
      exp[2] = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1};
      exp[3] = 13'd0;
      instr = 8'hC7;
      run   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         run   = 1'b0;
         instr = 8'h00;
         tests_run++;
         if (outs !== exp[i]) begin
            tests_failed++;
            $display("FAIL sub_step%0d: got %h expected %h", i + 1, outs, exp[i]);
         end
      end
   endtask

   task automatic test_back_to_back_mv();
      logic [12:0] exp [0:3];
      exp[1] = {3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
      exp[2] = {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
      exp[3] = {3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1};
      exp[0] = 13'd0;
      instr = 8'h26;
      run   = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         tests_run++;
         if (outs !== exp[i % 4]) begin
            tests_failed++;
            $display("FAIL mv_cycle%0d: got %h expected %h", i, outs, exp[i % 4]);
         end
         tests_run++;
         if ((int'(Rout) + int'(Gout) + int'(extOut)) > 1) begin
            tests_failed++;
            $display("FAIL mv_contention%0d: got Rout=%b Gout=%b extOut=%b required at most one", i, Rout, Gout, extOut);
         end
         if (i == 12) begin
            run = 1'b0;
         end else begin
            run = 1'b1;
         end
      end
      @(negedge clk);
      tests_run++;
      if (outs !== 13'd0) begin
         tests_failed++;
         $display("FAIL mv_stop: got %h expected %h", outs, 13'd0);
      end
   endtask

`ifdef SEQ_RETIRE_CNT_EN
   task automatic test_retire_wrap();
      int dones = 0;
      int cycles = 0;
      rst = 1'b0;
      @(negedge clk);
      rst   = 1'b1;
      instr = 8'h68;
      run   = 1'b1;
      while (dones < 257 && cycles < 600) begin
         @(negedge clk);
         cycles++;
         if (done === 1'b1) begin
            dones++;
            if (dones == 256) begin
               tests_run++;
               if (retired !== 8'hFF) begin
                  tests_failed++;
                  $display("FAIL retire_before_wrap: got %h expected %h", retired, 8'hFF);
               end
            end
         end
      end
      run = 1'b0;
      tests_run++;
      if (dones != 257) begin
         tests_failed++;
         $display("FAIL retire_timeout: got %0d dones expected 257", dones);
      end
      @(negedge clk);
      tests_run++;
      if (retired !== 8'h01) begin
         tests_failed++;
         $display("FAIL retire_wrap: got %h expected %h", retired, 8'h01);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_reset_mid_add();
      test_mvi();
      test_add();
      test_sub_instr_change();
      test_back_to_back_mv();
`ifdef SEQ_RETIRE_CNT_EN
      test_retire_wrap();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
